uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority bit decision,
// optional parity and 1-2 stop bits, with a small receive FIFO and sticky overrun flag.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 get,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int          M         = CLKS_PER_BIT / 2;
  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] SMP0      = 16'(M - 1);
  localparam logic [15:0] SMP1      = 16'(M);
  localparam logic [15:0] SMP2      = 16'(M + 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CNTW      = AW + 1;
  localparam int          EW        = DATA_BITS + 2;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               state, state_n;
  logic [15:0]          cnt, cnt_n;
  logic [3:0]           bit_idx, idx_n;
  logic                 sync1, sync2, hist;
  logic [2:0]           warm;
  logic                 start_edge, at_wrap, at_dec, maj;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic                 push_req;
  logic [EW-1:0]        push_data;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 full, pop, push_ok, drop;
  logic [EW-1:0]        head;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_flag(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY == 2) ? x : ~x;
  endfunction

  // Input synchroniser; warm gates edge detection until the flops hold real line samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
      warm  <= '0;
    end else begin
      sync1 <= get;
      sync2 <= sync1;
      hist  <= sync2;
      warm  <= {warm[1:0], 1'b1};
    end
  end

  assign start_edge = warm[2] & hist & ~sync2;
  assign at_wrap    = (cnt == CNT_LAST);
  assign at_dec     = (cnt == SMP2);
  assign maj        = maj3(s0, s1, sync2);
  assign busy       = (state != ST_IDLE);

  // Receive FSM: control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (cnt == SMP0) s0 <= sync2;
    if (cnt == SMP1) s1 <= sync2;
    sh   <= sh_n;
    perr <= perr_n;
    ferr <= ferr_n;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = bit_idx;
    sh_n     = sh;
    perr_n   = perr;
    ferr_n   = ferr;
    push_req = 1'b0;
    if (state != ST_IDLE) cnt_n = at_wrap ? '0 : cnt + 16'd1;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (start_edge) begin
          state_n = ST_START;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      ST_START: begin
        if (at_dec && maj) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (at_wrap) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_dec) sh_n = {maj, sh[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (bit_idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = bit_idx + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (at_dec) perr_n = par_flag(sh, maj);
        if (at_wrap) state_n = ST_STOP;
      end
      ST_STOP: begin
        // Push at the last stop-bit decision so the next start edge is not missed
        if (at_dec) begin
          ferr_n = ferr | ~maj;
          if (bit_idx == LAST_STOP) begin
            push_req = 1'b1;
            state_n  = ST_IDLE;
            cnt_n    = '0;
            idx_n    = '0;
          end
        end else if (at_wrap) begin
          idx_n = bit_idx + 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign push_data = {sh, perr, ferr_n};

  // Receive FIFO
  assign full    = (count == CNTW'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out        = out_valid ? head[EW-1:2] : '0;
  assign parity_err = out_valid & head[1];
  assign frame_err  = out_valid & head[0];

endmodule
